// File: rtl/reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_if
// Bundle of the requester handshake, clear control and reg_file write port
// signals that pass through reg_write_arbiter.
//   req_valid/req_addr/req_data : packed per-requester write requests
//   req_ready                   : one-hot accept back to the requesters
//   clr_start/clr_busy          : clear-sweep request and progress flag
//   wr_en/wr_addr/wr_data       : write port driving reg_file
// master = requester/consumer side, slave = the arbiter itself.
// -----------------------------------------------------------------------------
interface reg_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      clr_start;
   logic                      clr_busy;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_data;

   modport master (
      output req_valid, req_addr, req_data, clr_start,
      input  req_ready, clr_busy, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  req_valid, req_addr, req_data, clr_start,
      output req_ready, clr_busy, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin arbiter sharing the single reg_file write port among NUM_REQ
// requesters, with a built-in sequencer that sweeps zeros into every register.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : reg_write_arbiter_if.slave (requests, ready, clear, write port)
// req_ready is combinational; clr_busy and the write port are registered.
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   reg_write_arbiter_if.slave  bus
);
   localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_q;
   logic [PTR_W-1:0]    rr_ptr_q;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic                clr_busy_q;

   logic                grant_vld;
   logic [PTR_W-1:0]    grant_idx;
   logic [PTR_W:0]      cand;
   logic [PTR_W-1:0]    next_ptr;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;
   logic                grant_ok;
   logic                accept;

   // Scan from the farthest candidate back to rr_ptr so the last hit (the
   // first valid at or after rr_ptr, wrapping) is the one that sticks.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_REQ)) begin
            cand = cand - (PTR_W+1)'(NUM_REQ);
         end
         if (bus.req_valid[cand[PTR_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PTR_W'(i)) begin
            win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            win_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign next_ptr = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

   // A pending clear outranks every requester; ready is also forced low
   // while reset is held so nothing is handed a false accept.
   assign grant_ok      = rst && (state_q == IDLE) && !bus.clr_start && grant_vld;
   assign bus.req_ready = grant_ok ? (NUM_REQ'(1) << grant_idx) : '0;
   assign accept        = |(bus.req_valid & bus.req_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         clr_cnt_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         clr_busy_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Any cycle spent in IDLE ends the busy window, so busy covers
               // exactly the final clear write issued on the CLEAR->IDLE edge.
               clr_busy_q <= 1'b0;
               if (bus.clr_start) begin
                  state_q    <= CLEAR;
                  clr_cnt_q  <= '0;
                  clr_busy_q <= 1'b1;
                  wr_en_q    <= 1'b0;
               end else if (accept) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= win_addr;
                  wr_data_q <= win_data;
                  rr_ptr_q  <= next_ptr;
               end else begin
                  wr_en_q <= 1'b0;
               end
            end
            CLEAR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= clr_cnt_q;
               wr_data_q <= '0;
               clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
               if (clr_cnt_q == ADDR_W'(NUM_REGS-1)) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               wr_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.clr_busy = clr_busy_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 2;
   localparam int DATA_W  = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [DATA_W-1:0] rf [0:3];

   reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   reg_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reg_file write port (no reset, like the real reg_file).
   always @(posedge clk) begin
      if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
      bus.req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.req_valid = '0;
      bus.clr_start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.clr_start = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), DATA_W'(8'hA0 + i));
      bus.req_valid = 4'b1111;
      repeat (5) tick();
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b exp 0", bus.wr_en); end
      checks++; if (bus.wr_addr !== 2'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d exp 0", bus.wr_addr); end
      checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h exp 00", bus.wr_data); end
      checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b exp 0", bus.clr_busy); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", bus.req_ready); end
      rst = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b exp 0001", bus.req_ready); end
      tick();
      bus.req_valid = '0;
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 2'd0 || bus.wr_data !== 8'hA0)
         begin errors++; $display("FAIL reset_first_write: got en=%b a=%0d d=%h exp en=1 a=0 d=a0", bus.wr_en, bus.wr_addr, bus.wr_data); end
   endtask

   task automatic test_single_write();
      do_reset();
      set_req(1, 2'd2, 8'h5A);
      bus.req_valid = 4'b0010;
      #1;
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b exp 0010", bus.req_ready); end
      tick();
      bus.req_valid = '0;
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 2'd2 || bus.wr_data !== 8'h5A)
         begin errors++; $display("FAIL single_write: got en=%b a=%0d d=%h exp en=1 a=2 d=5a", bus.wr_en, bus.wr_addr, bus.wr_data); end
      tick();
      checks++; if (rf[2] !== 8'h5A) begin errors++; $display("FAIL single_readback: got %h exp 5a", rf[2]); end
      checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 2'd2 || bus.wr_data !== 8'h5A)
         begin errors++; $display("FAIL single_idle_hold: got en=%b a=%0d d=%h exp en=0 a=2 d=5a", bus.wr_en, bus.wr_addr, bus.wr_data); end
   endtask

   task automatic test_fairness();
      int exp_g [5] = '{0, 1, 2, 3, 0};
      logic [NUM_REQ-1:0] exp_rdy;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), DATA_W'(8'hB0 + i));
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         exp_rdy = 4'b0001 << exp_g[c];
         #1;
         checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready[%0d]: got %b exp %b", c, bus.req_ready, exp_rdy); end
         tick();
         checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== DATA_W'(8'hB0 + exp_g[c]))
            begin errors++; $display("FAIL fair_write[%0d]: got en=%b d=%h exp en=1 d=%h", c, bus.wr_en, bus.wr_data, 8'hB0 + exp_g[c]); end
      end
      bus.req_valid = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i), DATA_W'(8'hC0 + i));
      bus.req_valid = 4'b0100;
      tick();
      bus.req_valid = 4'b1001;
      #1;
      checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b exp 1000", bus.req_ready); end
      tick();
      checks++; if (bus.wr_data !== 8'hC3) begin errors++; $display("FAIL wrap_write3: got %h exp c3", bus.wr_data); end
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0: got %b exp 0001", bus.req_ready); end
      tick();
      bus.req_valid = '0;
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 8'hC0) begin errors++; $display("FAIL wrap_write0: got en=%b d=%h exp en=1 d=c0", bus.wr_en, bus.wr_data); end
      tick();
   endtask

   task automatic test_clear();
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         set_req(i, ADDR_W'(i), DATA_W'(8'h11 * (i + 1)));
         bus.req_valid = 4'b0001 << i;
         tick();
      end
      bus.req_valid = '0;
      tick();
      checks++; if (rf[0] !== 8'h11 || rf[1] !== 8'h22 || rf[2] !== 8'h33 || rf[3] !== 8'h44)
         begin errors++; $display("FAIL clear_preload: got %h %h %h %h exp 11 22 33 44", rf[0], rf[1], rf[2], rf[3]); end
      set_req(0, 2'd1, 8'h99);
      bus.req_valid = 4'b0001;
      bus.clr_start = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL clear_priority: got %b exp 0000", bus.req_ready); end
      tick();
      bus.clr_start = 1'b0;
      checks++; if (bus.clr_busy !== 1'b1 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL clear_enter: got busy=%b en=%b exp busy=1 en=0", bus.clr_busy, bus.wr_en); end
      for (int a = 0; a < 4; a++) begin
         tick();
         checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(a) || bus.wr_data !== 8'h00 || bus.clr_busy !== 1'b1)
            begin errors++; $display("FAIL clear_write[%0d]: got en=%b a=%0d d=%h busy=%b exp en=1 a=%0d d=00 busy=1", a, bus.wr_en, bus.wr_addr, bus.wr_data, bus.clr_busy, a); end
         checks++; if (bus.req_ready !== ((a == 3) ? 4'b0001 : 4'b0000))
            begin errors++; $display("FAIL clear_ready[%0d]: got %b exp %b", a, bus.req_ready, (a == 3) ? 4'b0001 : 4'b0000); end
         // A second start request mid-sweep must be ignored.
         bus.clr_start = (a == 0);
      end
      tick();
      bus.req_valid = '0;
      checks++; if (bus.clr_busy !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 2'd1 || bus.wr_data !== 8'h99)
         begin errors++; $display("FAIL clear_post_grant: got busy=%b en=%b a=%0d d=%h exp busy=0 en=1 a=1 d=99", bus.clr_busy, bus.wr_en, bus.wr_addr, bus.wr_data); end
      tick();
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL clear_no_restart: got en=%b exp 0", bus.wr_en); end
      checks++; if (rf[0] !== 8'h00 || rf[1] !== 8'h99 || rf[2] !== 8'h00 || rf[3] !== 8'h00)
         begin errors++; $display("FAIL clear_readback: got %h %h %h %h exp 00 99 00 00", rf[0], rf[1], rf[2], rf[3]); end
   endtask

   task automatic test_reset_mid_clear();
      do_reset();
      set_req(2, 2'd2, 8'h33);
      set_req(3, 2'd3, 8'h44);
      bus.req_valid = 4'b1100;
      tick();
      tick();
      bus.req_valid = '0;
      tick();
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      tick();
      tick();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 2'd1 || bus.clr_busy !== 1'b1)
         begin errors++; $display("FAIL midclr_addr1: got en=%b a=%0d busy=%b exp en=1 a=1 busy=1", bus.wr_en, bus.wr_addr, bus.clr_busy); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (bus.wr_en !== 1'b0 || bus.clr_busy !== 1'b0)
         begin errors++; $display("FAIL midclr_async: got en=%b busy=%b exp en=0 busy=0", bus.wr_en, bus.clr_busy); end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (rf[0] !== 8'h00 || rf[1] !== 8'h00 || rf[2] !== 8'h33 || rf[3] !== 8'h44)
         begin errors++; $display("FAIL midclr_regs: got %h %h %h %h exp 00 00 33 44", rf[0], rf[1], rf[2], rf[3]); end
      checks++; if (bus.wr_en !== 1'b0 || bus.clr_busy !== 1'b0)
         begin errors++; $display("FAIL midclr_idle: got en=%b busy=%b exp en=0 busy=0", bus.wr_en, bus.clr_busy); end
      bus.req_valid = 4'b0001;
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midclr_ready: got %b exp 0001", bus.req_ready); end
      bus.req_valid = '0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.clr_start = 1'b0;
      tick();
      test_reset();
      test_single_write();
      test_fairness();
      test_wrap();
      test_clear();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
